icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Direct-mapped instruction cache; responder end of the datapath instruction-fetch
//  request (imemREN/imemaddr -> ihit/imemload). Serves hits from a local tag/data array
//  same cycle; on a miss, fetches the word from memory over the iREN/iaddr/iwait/iload
//  handshake, fills the line, then serves the retried request. Sits between the
//  pipeline fetch stage and the memory controller.
// PARAMETERS
//  SETS      16   number of one-word lines (power of 2, >=2); IDXW=$clog2(SETS)
//  CNTW      32   width of perf counters hit_count / miss_count
// PORTS
//  CLK        in   1     clock, all state updates on rising edge
//  nRST       in   1     synchronous active-low reset, sampled on rising CLK
//  imemREN    in   1     datapath fetch request
//  imemaddr   in   32    fetch byte address; [1:0] ignored
//  flush      in   1     invalidate all lines (asserted at halt)
//  ihit       out  1     request satisfied this cycle; imemload valid
//  imemload   out  32    instruction word
//  iREN       out  1     memory read request
//  iaddr      out  32    memory word address ({tag,idx,2'b00})
//  iwait      in   1     memory busy; iload valid in a cycle iREN=1 and iwait=0
//  iload      in   32    memory read data
//  hit_count  out  CNTW  number of ihit cycles since reset
//  miss_count out  CNTW  number of completed fills since reset
// BEHAVIOUR
//  Address split: idx=imemaddr[IDXW+1:2], tag=imemaddr[31:IDXW+2].
//  Array per line: valid(1), tag(30-IDXW), data(32). Array is not reset; valids are.
//  Reset (nRST=0 at edge): state<=IDLE, all valid<=0, counters<=0, miss_addr<=0.
//   Outputs during/after reset: ihit=0, iREN=0, imemload=0, iaddr=0.
//  FSM states IDLE, FETCH:
//   IDLE: hit = imemREN & valid[idx] & tag match -> ihit=1, imemload=data[idx]
//    combinationally (zero-cycle latency), hit_count++ at edge.
//    miss (imemREN & !hit) -> latch miss_addr<=imemaddr, go FETCH. ihit=0.
//    imemREN=0 -> ihit=0, imemload=0, stay.
//   FETCH: iREN=1, iaddr={miss_addr[31:2],2'b00}; ihit=0.
//    iwait=1 -> stay. iwait=0 -> write data=iload, tag, valid=1 at miss_addr idx;
//    miss_count++; go IDLE. Retried request hits next cycle (miss latency = 1 + memory
//    wait cycles + 1).
//   Fill completes even if imemREN drops or imemaddr changes mid-FETCH (no bus abort);
//    the filled line is kept.
//  flush: at the edge all valid<=0. In FETCH, the in-flight fill still completes and
//   its line is valid after (fill wins over flush for that index on the same edge).
//   ihit forced 0 in any cycle flush=1.
//  Counters wrap modulo 2^CNTW, no saturation.
//  Combinational paths: imemREN/imemaddr -> ihit/imemload; no comb path iwait->iREN.
//  Reset asserted mid-FETCH: returns to IDLE, iREN drops next cycle, fill discarded.
// TESTING
//  Cold fetch: reset, imemREN=1, addr 0x0, iwait=1 for 2 cycles then 0 with
//   iload=0x2000_0004 -> iREN high 3 cycles, iaddr=0x0, ihit=1 next cycle, miss_count=1.
//  Hit: re-request 0x0 -> ihit=1 same cycle, imemload=0x2000_0004, hit_count increments.
//  Conflict (SETS=16): fill 0x0, then 0x40 (same idx 0, new tag) -> miss, fill, then
//   0x0 misses again; miss_count=3.
//  Flush: fill 0x4 and 0x8, pulse flush 1 cycle -> both re-requests miss (iREN=1).
//  Abort: miss on 0xC, drop imemREN during FETCH, finish iwait -> line valid;
//   later 0xC hits with no iREN.
//  Reset mid-FETCH: nRST=0 one cycle while iREN=1 -> iREN=0, counters=0, 0xC misses.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder.
// Hits are served combinationally; misses fetch the word over the iREN/iwait handshake and fill the line.
module icache_responder #(
    parameter int SETS = 16,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    input  logic            flush,
    output logic            ihit,
    output logic [31:0]     imemload,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  logic [31:0]     iload,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, next_state;

    logic [SETS-1:0] valid;
    logic [TAGW-1:0] tag_array  [SETS];
    logic [31:0]     data_array [SETS];
    logic [31:0]     miss_addr;

    logic [IDXW-1:0] req_idx, fill_idx;
    logic [TAGW-1:0] req_tag, fill_tag;
    logic            lookup_hit;
    logic            fill_done;
    logic            miss;

    assign req_idx  = imemaddr[IDXW+1:2];
    assign req_tag  = imemaddr[31:IDXW+2];
    assign fill_idx = miss_addr[IDXW+1:2];
    assign fill_tag = miss_addr[31:IDXW+2];

    assign lookup_hit = imemREN && valid[req_idx] && (tag_array[req_idx] == req_tag);

    // iREN/iaddr depend only on state, so iwait never reaches them combinationally.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        fill_done  = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE: begin
                if (lookup_hit && !flush) begin
                    ihit     = 1'b1;
                    imemload = data_array[req_idx];
                end else if (imemREN && !lookup_hit) begin
                    miss       = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_addr[31:2], 2'b00};
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!nRST) begin
            ihit      = 1'b0;
            imemload  = 32'h0;
            iREN      = 1'b0;
            iaddr     = 32'h0;
            fill_done = 1'b0;
            miss      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            miss_addr  <= 32'h0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss)
                miss_addr <= imemaddr;
            if (ihit)
                hit_count <= hit_count + CNTW'(1);
            if (fill_done)
                miss_count <= miss_count + CNTW'(1);
        end
    end

    // A fill landing on the same edge as a flush keeps its line valid.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
        end else begin
            if (flush)
                valid <= '0;
            if (fill_done)
                valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_array[fill_idx]  <= fill_tag;
            data_array[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized fetches
// compared against a behavioural cache model (valid/tag/data tables and counters).
module tb_icache_responder;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          exp_hits;
    int          exp_misses;

    icache_responder #(.SETS(16), .CNTW(32)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        int idx;
        idx = int'((addr / 4) % 16);
        return m_valid[idx] && (m_tag[idx] == addr[31:6]);
    endfunction

    function automatic void model_fill(input logic [31:0] addr, input logic [31:0] word);
        int idx;
        idx = int'((addr / 4) % 16);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[31:6];
        m_data[idx]  = word;
    endfunction

    task automatic check_counters(input string tag);
        @(negedge CLK);
        imemREN = 1'b0; flush = 1'b0; iwait = 1'b1;
        #1;
        checks++;
        if (hit_count !== 32'(exp_hits)) begin
            errors++;
            $display("[TB] FAIL %s hit_count: got %0d expected %0d", tag, hit_count, exp_hits);
        end
        checks++;
        if (miss_count !== 32'(exp_misses)) begin
            errors++;
            $display("[TB] FAIL %s miss_count: got %0d expected %0d", tag, miss_count, exp_misses);
        end
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle outputs: got ihit=%b imemload=%h iREN=%b expected 0/0/0",
                     tag, ihit, imemload, iREN);
        end
    endtask

    // One fetch: hit in the same cycle, or miss -> waits -> fill -> retried hit.
    task automatic do_fetch(input logic [31:0] addr, input int waits, input logic [31:0] word);
        int idx;
        idx = int'((addr / 4) % 16);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = addr; flush = 1'b0; iwait = 1'b1;
        #1;
        if (model_hit(addr)) begin
            checks++;
            if (ihit !== 1'b1 || imemload !== m_data[idx]) begin
                errors++;
                $display("[TB] FAIL hit %h: got ihit=%b data=%h expected ihit=1 data=%h",
                         addr, ihit, imemload, m_data[idx]);
            end
            exp_hits++;
        end else begin
            checks++;
            if (ihit !== 1'b0) begin
                errors++;
                $display("[TB] FAIL miss %h: got ihit=%b expected 0", addr, ihit);
            end
            for (int i = 0; i <= waits; i++) begin
                @(negedge CLK);
                iwait = (i < waits);
                iload = word;
                #1;
                checks++;
                if (iREN !== 1'b1 || iaddr !== {addr[31:2], 2'b00} || ihit !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fetch %h: got iREN=%b iaddr=%h ihit=%b expected 1/%h/0",
                             addr, iREN, iaddr, ihit, {addr[31:2], 2'b00});
                end
            end
            model_fill(addr, word);
            exp_misses++;
            @(negedge CLK);
            iwait = 1'b1;
            #1;
            checks++;
            if (ihit !== 1'b1 || imemload !== word || iREN !== 1'b0) begin
                errors++;
                $display("[TB] FAIL retry %h: got ihit=%b data=%h iREN=%b expected 1/%h/0",
                         addr, ihit, imemload, iREN, word);
            end
            exp_hits++;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0; iwait = 1'b1; iload = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || imemload !== 32'h0 || iaddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got ihit=%b iREN=%b imemload=%h iaddr=%h expected zeros",
                     ihit, iREN, imemload, iaddr);
        end
        nRST = 1'b1;
        model_reset();
        check_counters("reset");
    endtask

    task automatic test_cold_fetch();
        do_fetch(32'h0, 2, 32'h2000_0004);
        check_counters("cold");
    endtask

    task automatic test_hit();
        do_fetch(32'h0, 0, 32'hDEAD_BEEF);
        do_fetch(32'h3, 0, 32'hDEAD_BEEF);
        check_counters("hit");
    endtask

    task automatic test_conflict();
        do_fetch(32'h40, 1, 32'h1111_0040);
        do_fetch(32'h0, 0, 32'h2222_0000);
        do_fetch(32'h0, 0, 32'h0);
        check_counters("conflict");
    endtask

    task automatic test_flush();
        do_fetch(32'h4, 0, 32'hAAAA_0004);
        do_fetch(32'h8, 1, 32'hBBBB_0008);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h4; flush = 1'b1;
        #1;
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush ihit: got %b expected 0", ihit);
        end
        model_flush();
        do_fetch(32'h4, 0, 32'hCCCC_0004);
        do_fetch(32'h8, 0, 32'hDDDD_0008);
        check_counters("flush");
    endtask

    task automatic test_abort();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'hC; iwait = 1'b1;
        @(negedge CLK);
        imemREN = 1'b0; imemaddr = 32'h80;
        @(negedge CLK);
        iwait = 1'b0; iload = 32'h5EED_000C;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'hC) begin
            errors++;
            $display("[TB] FAIL abort fetch: got iREN=%b iaddr=%h expected 1/0000000c", iREN, iaddr);
        end
        model_fill(32'hC, 32'h5EED_000C);
        exp_misses++;
        check_counters("abort");
        do_fetch(32'hC, 0, 32'h0);
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h4C; iwait = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset pre: got iREN=%b expected 1", iREN);
        end
        nRST = 1'b0; iwait = 1'b0; iload = 32'hBAD0_BAD0;
        @(negedge CLK);
        nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
        #1;
        checks++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset iREN: got %b expected 0", iREN);
        end
        model_reset();
        check_counters("midreset");
        do_fetch(32'hC, 1, 32'h0C0C_0C0C);
        check_counters("after_midreset");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    @(negedge CLK);
                    imemREN = 1'b0; flush = 1'b1;
                    model_flush();
                    @(negedge CLK);
                    flush = 1'b0;
                end
                1: check_counters("rand_idle");
                default: begin
                    addr = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
                           | 32'($urandom_range(0, 3));
                    do_fetch(addr, int'($urandom_range(0, 3)), $urandom);
                end
            endcase
        end
        check_counters("random");
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_hit();
        test_conflict();
        test_flush();
        test_abort();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
